sigma_weighted_sum: RTL and testbench

Computes the weighted sum of N_POINTS sigma-point vectors, P = sum over i of w_i * X_i, element-wise over LENGTH signed 32-bit elements into 64-bit accumulators. This is the sequencing and accumulation stage paired with vector_scale_add. It accepts one (weight, vector) pair per handshake and feeds its running sum back as the addend, so the accumulator plays the role of Y. It produces the weighted mean or state vector consumed by the covariance stages.

---
 rtl/sigma_weighted_sum.sv | 115 +++++++++++
 tb/tb_sigma_weighted_sum.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_weighted_sum.sv
// Weighted sum of N_POINTS sigma-point vectors: P[k] = sum_i w_i * X_i[k], 64-bit wrapping accumulators.
// Latency: MAC_LATENCY cycles per accepted (w, X) pair; result valid MAC_LATENCY+1 cycles after the last handshake.
// Backpressure: in_ready only in ACCEPT; result held in HOLD until out_ready; ce low freezes state and masks handshakes.
module sigma_weighted_sum #(
   parameter int LENGTH      = 5,
   parameter int N_POINTS    = 11,
   parameter int MAC_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     sclr,
   input  logic                     ce,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              w,
   input  logic [32*LENGTH-1:0]     X,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [64*LENGTH-1:0]     P,
   output logic                     busy
);

   localparam int CW = $clog2(N_POINTS + 1);
   localparam int MW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ACCEPT, COMPUTE, HOLD} state_t;

   state_t                 state;
   logic [CW-1:0]          count;
   logic [MW-1:0]          mac_cnt;
   logic [31:0]            w_q;
   logic [32*LENGTH-1:0]   x_q;
   logic [64*LENGTH-1:0]   acc;
   logic [64*LENGTH-1:0]   acc_next;
   logic                   ready_q;
   logic                   valid_q;
   logic                   busy_q;

   // Running sum plus the latched pair's products; operands sign-extended to 64 bits so the
   // low 64 bits of the product are the exact signed 32x32 result.
   always_comb begin
      acc_next = acc;
      for (int k = 0; k < LENGTH; k++) begin
         acc_next[k*64 +: 64] = acc[k*64 +: 64] +
            ({{32{w_q[31]}}, w_q} * {{32{x_q[32*k+31]}}, x_q[32*k +: 32]});
      end
   end

   // Sequencing FSM with registered handshake/status flags; the accumulator is updated only on
   // the final COMPUTE cycle, which models the multiply-accumulate pipeline depth.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state   <= IDLE;
         count   <= '0;
         mac_cnt <= '0;
         w_q     <= '0;
         x_q     <= '0;
         acc     <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc     <= '0;
                  count   <= '0;
                  state   <= ACCEPT;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  w_q     <= w;
                  x_q     <= X;
                  mac_cnt <= MW'(MAC_LATENCY - 1);
                  state   <= COMPUTE;
                  ready_q <= 1'b0;
               end
            end
            COMPUTE: begin
               if (mac_cnt == '0) begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
                  if (count == CW'(N_POINTS - 1)) begin
                     state   <= HOLD;
                     valid_q <= 1'b1;
                  end else begin
                     state   <= ACCEPT;
                     ready_q <= 1'b1;
                  end
               end else begin
                  mac_cnt <= mac_cnt - 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags are masked by ce so nothing transfers while the block is frozen.
   assign in_ready  = ce & ready_q;
   assign out_valid = ce & valid_q;
   assign busy      = busy_q;
   assign P         = acc;

endmodule

// File: tb/tb_sigma_weighted_sum.sv
// Self-checking bench: three instances (N_POINTS = 3, 4, 1; LENGTH = 2; MAC_LATENCY = 4) share stimulus.
// A selector picks the instance under test; expected sums come from a plain 64-bit arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sigma_weighted_sum;

   localparam int L = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sclr = 1'b0, ce = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0]   w = '0;
   logic [63:0]   X = '0;

   logic          rdy0, rdy1, rdy2, vld0, vld1, vld2, bsy0, bsy1, bsy2;
   logic [127:0]  p0, p1, p2;

   sigma_weighted_sum #(.LENGTH(L), .N_POINTS(3), .MAC_LATENCY(4)) u0 (
      .clk(clk), .sclr(sclr), .ce(ce), .start(start), .in_valid(in_valid), .in_ready(rdy0),
      .w(w), .X(X), .out_valid(vld0), .out_ready(out_ready), .P(p0), .busy(bsy0));
   sigma_weighted_sum #(.LENGTH(L), .N_POINTS(4), .MAC_LATENCY(4)) u1 (
      .clk(clk), .sclr(sclr), .ce(ce), .start(start), .in_valid(in_valid), .in_ready(rdy1),
      .w(w), .X(X), .out_valid(vld1), .out_ready(out_ready), .P(p1), .busy(bsy1));
   sigma_weighted_sum #(.LENGTH(L), .N_POINTS(1), .MAC_LATENCY(4)) u2 (
      .clk(clk), .sclr(sclr), .ce(ce), .start(start), .in_valid(in_valid), .in_ready(rdy2),
      .w(w), .X(X), .out_valid(vld2), .out_ready(out_ready), .P(p2), .busy(bsy2));

   int            sel = 0;
   logic          c_rdy, c_vld, c_bsy;
   logic [127:0]  c_p;

   always_comb begin
      c_rdy = rdy0; c_vld = vld0; c_bsy = bsy0; c_p = p0;
      case (sel)
         1: begin c_rdy = rdy1; c_vld = vld1; c_bsy = bsy1; c_p = p1; end
         2: begin c_rdy = rdy2; c_vld = vld2; c_bsy = bsy2; c_p = p2; end
         default: ;
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tot = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // point table: weight, element 0, element 1
   logic [31:0] pw [16];
   logic [31:0] pxa[16];
   logic [31:0] pxb[16];

   task automatic model(input int first, input int n, output logic [63:0] e0, output logic [63:0] e1);
      longint s0 = 0;
      longint s1 = 0;
      for (int i = first; i < first + n; i++) begin
         s0 += longint'($signed(pw[i])) * longint'($signed(pxa[i]));
         s1 += longint'($signed(pw[i])) * longint'($signed(pxb[i]));
      end
      e0 = s0;
      e1 = s1;
   endtask

   function automatic logic [31:0] rnd_val();
      int r = $urandom_range(0, 5);
      if (r == 0) return 32'h8000_0000;
      if (r == 1) return 32'h7FFF_FFFF;
      if (r == 2) return $urandom_range(0, 20);
      return $urandom;
   endfunction

   task automatic do_reset();
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
   endtask

   task automatic begin_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", c_bsy, 1'b1);
   endtask

   // Present point i and wait (bounded) for the handshake; returns the handshake cycle.
   task automatic send(input int i, input bit hold, output int hs);
      int n = 0;
      w = pw[i];
      X = {pxb[i], pxa[i]};
      in_valid = 1'b1;
      while (!c_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("handshake_timeout", 1'b0, 1'b1);
      hs = cyc;
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      w = $urandom;
      X = {$urandom, $urandom};
   endtask

   task automatic wait_out(output int oc);
      int n = 0;
      while (!c_vld && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("out_valid_timeout", 1'b0, 1'b1);
      oc = cyc;
   endtask

   task automatic check_sum(input string tag, input int first, input int n);
      logic [63:0] e0, e1;
      model(first, n, e0, e1);
      check({tag, "_e0"}, c_p[63:0], e0);
      check({tag, "_e1"}, c_p[127:64], e1);
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", c_vld, 1'b0);
      check("idle_busy", c_bsy, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, oc, hs;
      logic [127:0] snap;

      @(negedge clk);
      do_reset();
      check("rst_in_ready", c_rdy, 1'b0);
      check("rst_out_valid", c_vld, 1'b0);
      check("rst_busy", c_bsy, 1'b0);
      check("rst_p0", c_p[63:0], 64'd0);
      check("rst_p1", c_p[127:64], 64'd0);

      // basic sum and handshake timing with in_valid held high
      sel = 0;
      pw[0] = 32'd2;          pxa[0] = 32'd1;          pxb[0] = 32'd10;
      pw[1] = 32'hFFFF_FFFF;  pxa[1] = 32'd4;          pxb[1] = 32'hFFFF_FFFB;
      pw[2] = 32'd3;          pxa[2] = 32'h7FFF_FFFF;  pxb[2] = 32'd1;
      begin_run();
      send(0, 1'b1, t0);
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) @(negedge clk);
         check("ready_low_compute", c_rdy, 1'b0);
      end
      @(negedge clk);
      send(1, 1'b1, t1);
      send(2, 1'b0, t2);
      check("gap_01", 64'(t1 - t0), 64'd5);
      check("gap_12", 64'(t2 - t1), 64'd5);
      wait_out(oc);
      check("out_valid_cycle", 64'(oc - t2), 64'd5);
      check("basic_e0", c_p[63:0], 64'h0000_0001_7FFF_FFFB);
      check("basic_e1", c_p[127:64], 64'h0000_0000_0000_001C);
      check("busy_in_hold", c_bsy, 1'b1);

      // output back-pressure with a start pulse while holding
      snap = c_p;
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         @(negedge clk);
         check("hold_valid", c_vld, 1'b1);
         check("hold_p0", c_p[63:0], snap[63:0]);
         check("hold_p1", c_p[127:64], snap[127:64]);
      end
      start = 1'b0;
      finish_out();
      check("p_kept_after_idle", c_p[63:0], snap[63:0]);

      // wrap: four points of 2^31 * 2^31 sum to exactly 2^64
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pw[i] = 32'h8000_0000; pxa[i] = 32'h8000_0000; pxb[i] = 32'h8000_0000;
      end
      begin_run();
      for (int i = 0; i < 4; i++) send(i, 1'b0, hs);
      wait_out(oc);
      check("wrap_e0", c_p[63:0], 64'd0);
      check("wrap_e1", c_p[127:64], 64'd0);
      check_sum("wrap_model", 0, 4);
      finish_out();

      // single-point instance, negative weight
      sel = 2;
      do_reset();
      pw[0] = 32'hFFFF_FFFF; pxa[0] = 32'h8000_0000; pxb[0] = 32'd5;
      begin_run();
      send(0, 1'b0, t0);
      wait_out(oc);
      check("n1_out_cycle", 64'(oc - t0), 64'd5);
      check("neg_e0", c_p[63:0], 64'h0000_0000_8000_0000);
      check("neg_e1", c_p[127:64], 64'hFFFF_FFFF_FFFF_FFFB);
      finish_out();

      // synchronous reset during the second point's computation, then a clean run
      sel = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         pw[i] = rnd_val(); pxa[i] = rnd_val(); pxb[i] = rnd_val();
      end
      begin_run();
      send(0, 1'b0, hs);
      send(1, 1'b0, hs);
      @(negedge clk);
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0;
      check("abort_in_ready", c_rdy, 1'b0);
      check("abort_out_valid", c_vld, 1'b0);
      check("abort_busy", c_bsy, 1'b0);
      check("abort_p0", c_p[63:0], 64'd0);
      check("abort_p1", c_p[127:64], 64'd0);
      begin_run();
      for (int i = 2; i < 5; i++) send(i, 1'b0, hs);
      wait_out(oc);
      check_sum("after_abort", 2, 3);
      finish_out();

      // clock-enable stall of 7 cycles inside COMPUTE
      for (int i = 0; i < 3; i++) begin
         pw[i] = rnd_val(); pxa[i] = rnd_val(); pxb[i] = rnd_val();
      end
      begin_run();
      send(0, 1'b0, t0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         ce = 1'b0;
         #1;
         check("ce_low_in_ready", c_rdy, 1'b0);
         check("ce_low_out_valid", c_vld, 1'b0);
         @(negedge clk);
      end
      ce = 1'b1;
      send(1, 1'b0, t1);
      check("ce_shift", 64'(t1 - t0), 64'd12);
      send(2, 1'b0, hs);
      wait_out(oc);
      check_sum("ce_sum", 0, 3);
      finish_out();

      // start and in_valid together in IDLE
      for (int i = 0; i < 3; i++) begin
         pw[i] = rnd_val(); pxa[i] = rnd_val(); pxb[i] = rnd_val();
      end
      w = pw[0];
      X = {pxb[0], pxa[0]};
      in_valid = 1'b1;
      start = 1'b1;
      check("collision_no_ready", c_rdy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      check("collision_next_ready", c_rdy, 1'b1);
      send(0, 1'b0, hs);
      send(1, 1'b0, hs);
      send(2, 1'b0, hs);
      wait_out(oc);
      check_sum("collision_sum", 0, 3);
      finish_out();

      // randomized runs with gaps and output back-pressure
      for (int r = 0; r < 8; r++) begin
         int gap;
         for (int i = 0; i < 3; i++) begin
            pw[i] = rnd_val(); pxa[i] = rnd_val(); pxb[i] = rnd_val();
         end
         begin_run();
         for (int i = 0; i < 3; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            send(i, 1'b0, hs);
         end
         wait_out(oc);
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) @(negedge clk);
         check_sum("random_sum", 0, 3);
         finish_out();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
